uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//   Asynchronous serial receiver, 8N1 framing, LSB first, idle-high line.
//   Samples the rx pin at mid-bit using a baud counter and emits each byte as a
//   one-cycle valid pulse. It is the receive-side counterpart to the serial
//   transmitter and sits between the pin and the byte-level logic.
// PARAMETERS
//   CLOCK_RATE_HZ    100_000_000  system clock frequency
//   BAUD_RATE_HZ     10_000_000   line bit rate
//   CLOCKS_PER_BAUD  CLOCK_RATE_HZ/BAUD_RATE_HZ  clocks per bit; must be >= 4
// PORTS
//   clk        in   1  system clock, rising edge
//   rst        in   1  reset; asynchronous, active-high
//   rx         in   1  serial line, asynchronous to clk, idle high
//   data       out  8  last received byte; held until the next byte completes
//   valid      out  1  one-cycle pulse: data was updated with a good frame
//   frame_err  out  1  one-cycle pulse: stop bit sampled 0
//   parity_err out  1  one-cycle pulse: parity mismatch (0 if feature absent)
//   busy       out  1  high from start detect until return to IDLE
// BEHAVIOUR
// - Reset values: data=0, valid=0, frame_err=0, parity_err=0, busy=0,
//   FSM=IDLE, both synchroniser flops=1, counters=0.
// - rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
//   This adds 2 cycles of latency relative to the pin.
// - Baud counter, 32 bit: cleared on every state change, incremented while
//   busy. A sample point is reached when the count equals the per-state target.
// - States:
//   - IDLE: on rx_s 1->0 go to START, busy=1.
//   - START: sample at count CLOCKS_PER_BAUD/2-1 (mid start bit).
//     If rx_s=1 (glitch/false start): back to IDLE, no pulse.
//     Otherwise go to DATA with bit_counter=0.
//   - DATA: sample at count CLOCKS_PER_BAUD-1.
//     Shift rx_s into shift_reg[7] (right shift, so LSB arrives first).
//     bit_counter++. After the 8th sample go to STOP, or to PARITY if enabled.
//   - STOP: sample at count CLOCKS_PER_BAUD-1.
//     rx_s=1: data<=shift_reg, valid=1 next cycle.
//     rx_s=0: frame_err=1, data unchanged.
//     In either case go to IDLE (busy=0) on the same edge.
// - Latency: valid rises 1 clk after the mid-stop sample edge, i.e.
//   ~9.5 bit times + 3 clks after the start-bit falling edge at the pin.
// - Back-to-back frames: IDLE re-arms from mid-stop, so a start edge arriving
//   half a bit later is caught.
// - Break / stuck-low line: after frame_err, IDLE requires a new 1->0 edge, so
//   there is no repeated reception while the line stays low.
// - No flow control: a new frame overwrites data. A consumer must latch data
//   on valid.
// - rst asserted mid-frame: immediate return to reset values, no pulse; the
//   partial frame is discarded.
// CONFIGURATION
//   UART_RX_PARITY_EN defined:
//   - A PARITY state follows DATA and samples at CLOCKS_PER_BAUD-1.
//   - Even parity: expected = ^shift_reg.
//   - On mismatch, parity_err pulses together with the STOP outcome, and
//     valid is suppressed even if the stop bit is good.
//   - Frame length is 11 bits.
//   UART_RX_PARITY_EN undefined:
//   - No PARITY state; parity_err tied to 0; 8N1 only.
// TESTING (CLOCKS_PER_BAUD=10 unless noted)
// 1. Drive 0xA5 8N1 at 10 clk/bit.
//    -> one valid pulse, data=8'hA5, frame_err=0, busy falls the same cycle.
// 2. Send 0x00 then 0xFF back-to-back with zero idle gap.
//    -> two valid pulses, data=00 then FF, no error pulses.
// 3. Low glitch of 3 clks on the idle line.
//    -> busy high for ~5 clks, returns to IDLE, valid=0, frame_err=0.
// 4. Send 0x3C with the stop bit forced 0, then hold rx low 30 clks, then high.
//    -> one frame_err pulse, data keeps its previous value, no further
//    activity until a new edge.
// 5. Assert rst at bit 4 of 0x55, release, then send 0x81.
//    -> outputs zero during reset, next valid has data=8'h81.
// 6. With UART_RX_PARITY_EN, send 0x07: correct parity bit 1 -> valid;
//    wrong parity bit 0 -> parity_err=1, valid=0. Also run a 100 random-byte
//    loopback against the transmitter.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchroniser, mid-bit sampling from a baud counter, one-cycle result pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int CLOCK_RATE_HZ   = 100_000_000,
  parameter int BAUD_RATE_HZ    = 10_000_000,
  parameter int CLOCKS_PER_BAUD = CLOCK_RATE_HZ / BAUD_RATE_HZ
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  // CLOCKS_PER_BAUD must be at least 4 so the half-bit target stays meaningful.
  localparam logic [31:0] HALF_TGT = 32'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [31:0] FULL_TGT = 32'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic        rxMeta_q, rxS_q, rxPrev_q;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frameErr_q, frameErr_d;
`ifdef UART_RX_PARITY_EN
  logic        parityBad_q, parityBad_d;
  logic        parityErr_q, parityErr_d;
`endif

  // rxPrev_q holds the previous synchronised value so IDLE reacts only to a fresh falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxS_q    <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxS_q    <= rxMeta_q;
      rxPrev_q <= rxS_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frameErr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBad_q <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frameErr_q  <= frameErr_d;
`ifdef UART_RX_PARITY_EN
      parityBad_q <= parityBad_d;
      parityErr_q <= parityErr_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frameErr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityBad_d = parityBad_q;
    parityErr_d = 1'b0;
`endif
    if (state_q != IDLE) begin
      cnt_d = cnt_q + 32'd1;
    end

    // Every sample point restarts the counter, so each bit is timed from the previous sample.
    case (state_q)
      IDLE: begin
        if (rxPrev_q && !rxS_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_TGT) begin
          cnt_d = '0;
          if (rxS_q) begin
            state_d = IDLE;
          end else begin
            state_d  = DATA;
            bitCnt_d = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == FULL_TGT) begin
          cnt_d    = '0;
          shift_d  = {rxS_q, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_TGT) begin
          cnt_d       = '0;
          parityBad_d = rxS_q ^ (^shift_q);
          state_d     = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_TGT) begin
          cnt_d   = '0;
          state_d = IDLE;
`ifdef UART_RX_PARITY_EN
          parityErr_d = parityBad_q;
          if (rxS_q && !parityBad_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
`else
          if (rxS_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
`endif
          if (!rxS_q) begin
            frameErr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frameErr_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parityErr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
